// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// and buffers {pc, instr} pairs ahead of the IF/ID register.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   pause               - IF/ID holding; head entry is not consumed
//   redirect            - taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc         - new fetch target (bits [1:0] ignored)
//   imem_req/imem_addr  - fetch request and word address
//   imem_ready          - request accepted when imem_req && imem_ready
//   imem_rvalid/rdata   - in-order response
//   if_valid/if_pc/if_instr - presented instruction (NOP when not valid)
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   aq_mem [FIFO_DEPTH];
    logic [PW-1:0] aq_wr;
    logic [PW-1:0] aq_rd;
    logic [CW-1:0] outstanding;

    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] discard;

    logic          pop;
    logic          accept;
    logic          rsp;
    logic          push;
    logic [CW:0]   credits_used;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? pc_mem[rd_ptr] : 32'h0;
    assign if_instr  = if_valid ? instr_mem[rd_ptr] : NOP;
    assign imem_addr = fetch_pc;

    assign pop = if_valid && !pause && !redirect;

    // Credits cover both in-flight and buffered words, so a response
    // always has a free FIFO slot even while paused.
    assign credits_used = {1'b0, outstanding} + {1'b0, count}
                        - {{CW{1'b0}}, pop};
    assign imem_req = !rst && !redirect && (credits_used < DEPTH_W);
    assign accept   = imem_req && imem_ready;

    // A response can only belong to an accepted request.
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign push = rsp && !redirect && (discard == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            aq_wr       <= '0;
            aq_rd       <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            discard     <= '0;
        end else begin
            if (accept) begin
                aq_mem[aq_wr] <= fetch_pc;
                aq_wr         <= aq_wr + 1'b1;
            end
            if (rsp) begin
                aq_rd <= aq_rd + 1'b1;
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp);

            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Every request still in flight is now wrong-path,
                // including ones already marked by an earlier redirect;
                // the one returning this cycle is dropped here.
                discard  <= outstanding - CW'(rsp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    pc_mem[wr_ptr]    <= aq_mem[aq_rd];
                    instr_mem[wr_ptr] <= imem_rdata;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
                if (rsp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch.
// In-order memory model plus scoreboard.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_tests = 0;
  int n_fail = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC  (RPC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  always begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (imem_rvalid && mq.size() > 0)
        void'(mq.pop_front());
      if (imem_req && imem_ready)
        mq.push_back('{imem_addr, cyc + lat});
    end
    cyc++;
    #1;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ KEY;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && !pause && !redirect) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("stream_pc", if_pc, mon_e.pc);
          chk("stream_instr", if_instr, mon_e.instr);
        end
      end else if (!if_valid) begin
        chk("idle_pc", if_pc, 32'h0);
        chk("idle_instr", if_instr, NOP);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic next();
    step();
    @(negedge clk);
  endtask

  task automatic stream(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    for (int i = 0; i < 200; i++) begin
      a = start + 32'(4 * i);
      sb.push_back('{a, a ^ KEY});
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
      next();
    end
  endtask

  task automatic wait_acc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_ready) begin
        ok = 1'b1;
        break;
      end
      next();
    end
  endtask

  task automatic wait_inflight2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mq.size() == 2 && !imem_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit          ok;
  logic        pr_acc;
  logic        pr_stall;
  logic [31:0] pr_addr;

  initial begin
    stream(RPC);
    step();
    step();
    @(negedge clk);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RPC);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, RPC);
    next();
    chk("lat_c1_valid", if_valid, 1'b0);
    next();
    chk("lat_c2_valid", if_valid, 1'b1);
    chk("lat_c2_pc", if_pc, RPC);
    next();
    chk("c3_valid", if_valid, 1'b1);
    chk("c3_pc", if_pc, RPC + 32'h4);

    step();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_pc", if_pc, RPC + 32'h8);
      chk("pause_instr", if_instr,
          (RPC + 32'h8) ^ KEY);
      chk("pause_noreq", imem_req, 1'b0);
      step();
    end
    pause = 1'b0;
    @(negedge clk);
    chk("rel_pc", if_pc, RPC + 32'h8);
    chk("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, RPC + 32'h10);
    next();
    chk("rel_next_pc", if_pc, RPC + 32'hC);
    next();
    next();

    lat = 3;
    wait_inflight2(ok);
    chk("rd_setup", ok, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_2003;
    stream(32'h0000_2000);
    @(negedge clk);
    chk("rd_noreq", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("rd_n1_valid", if_valid, 1'b0);
    wait_acc(ok);
    chk("rd_acc_seen", ok, 1'b1);
    chk("rd_first_addr", imem_addr, 32'h0000_2000);
    wait_valid(ok);
    chk("rd_valid_seen", ok, 1'b1);
    chk("rd_first_pc", if_pc, 32'h0000_2000);

    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_rvalid && if_valid && mq.size() == 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("co_setup", ok, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFA;
    stream(32'hFFFF_FFF8);
    @(negedge clk);
    chk("co_noreq", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    chk("co_n1_valid", if_valid, 1'b0);
    chk("co_n1_req", imem_req, 1'b1);
    chk("co_n1_addr", imem_addr, 32'hFFFF_FFF8);
    next();
    chk("co_n2_valid", if_valid, 1'b0);
    next();
    chk("co_n3_valid", if_valid, 1'b1);
    chk("co_n3_pc", if_pc, 32'hFFFF_FFF8);
    next();
    next();
    chk("wrap_pc", if_pc, 32'h0000_0000);
    next();

    lat = 3;
    wait_inflight2(ok);
    chk("b2b_setup", ok, 1'b1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    stream(32'h0000_3000);
    step();
    redirect_pc = 32'h0000_4000;
    stream(32'h0000_4000);
    step();
    redirect = 1'b0;
    @(negedge clk);
    wait_valid(ok);
    chk("b2b_valid_seen", ok, 1'b1);
    chk("b2b_first_pc", if_pc, 32'h0000_4000);

    lat = 1;
    pr_acc = 1'b0;
    pr_stall = 1'b0;
    pr_addr = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      imem_ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge clk);
      if (pr_stall)
        chk("bp_hold", imem_addr, pr_addr);
      else if (pr_acc)
        chk("bp_adv", imem_addr, pr_addr + 32'h4);
      pr_acc = imem_req && imem_ready;
      pr_stall = imem_req && !imem_ready;
      pr_addr = imem_addr;
    end
    step();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) next();

    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_valid && mq.size() == 1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mr_setup", ok, 1'b1);
    pause = 1'b1;
    rst = 1'b1;
    stream(RPC);
    step();
    rst = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    chk("mr_valid", if_valid, 1'b0);
    chk("mr_pc", if_pc, 32'h0);
    chk("mr_instr", if_instr, NOP);
    chk("mr_req", imem_req, 1'b1);
    chk("mr_addr", imem_addr, RPC);
    wait_valid(ok);
    chk("mr_valid_seen", ok, 1'b1);
    chk("mr_first_pc", if_pc, RPC);
    for (int i = 0; i < 4; i++) next();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
